// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 16:1 single-bit mux. It steps the select through the enabled
// channels, waits a settle time on each, samples mux_out, and returns a 16-bit word.
module mux_scan_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ch_mask,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        busy,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready
);

  localparam int unsigned NCH   = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE);
  localparam bit               HAS_SETTLE = (SETTLE != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [NCH-1:0]     word_q, word_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  logic               first_found;
  logic [SEL_W-1:0]   first_idx;
  logic               next_found;
  logic [SEL_W-1:0]   next_idx;

  // Priority searches: lowest set bit of the incoming mask, and lowest set bit of the
  // latched mask strictly above the current select (no wrap-around).
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!first_found && ch_mask[i]) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(i);
      end
      if (!next_found && mask_q[i] && (SEL_W'(i) > sel_q)) begin
        next_found = 1'b1;
        next_idx   = SEL_W'(i);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    word_d  = word_q;
    busy_d  = busy_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = ch_mask;
          word_d = '0;
          busy_d = 1'b1;
          cnt_d  = SETTLE_LD;
          if (first_found) begin
            sel_d   = first_idx;
            state_d = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
          end else begin
            // Empty mask: pass through one non-writing sample cycle so the word
            // becomes valid one cycle after accept, select untouched.
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (mask_q[sel_q]) begin
          word_d[sel_q] = mux_out;
        end
        if (next_found) begin
          sel_d   = next_idx;
          cnt_d   = SETTLE_LD;
          state_d = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
        end else begin
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (word_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: three instances (SETTLE = 0, 1, 3) share the
// control inputs; each phase checks one instance against hand-computed values.
module tb_mux_scan_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        word_ready;
  logic [15:0] ch_mask;
  logic [15:0] in_pat;

  logic [3:0]  sel0, sel1, sel3;
  logic        busy0, busy1, busy3;
  logic [15:0] word0, word1, word3;
  logic        valid0, valid1, valid3;
  logic        mo0, mo1, mo3;

  int checks   = 0;
  int failures = 0;
  int cur      = 1;

  logic [3:0]  c_sel;
  logic        c_busy;
  logic        c_valid;
  logic [15:0] c_word;

  always #5 clk = ~clk;

  // Bench-side model of the 16:1 mux feeding each instance.
  assign mo0 = in_pat[sel0];
  assign mo1 = in_pat[sel1];
  assign mo3 = in_pat[sel3];

  mux_scan_seq #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .sel(sel0),
    .mux_out(mo0), .busy(busy0), .word(word0), .word_valid(valid0), .word_ready(word_ready)
  );
  mux_scan_seq #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .sel(sel1),
    .mux_out(mo1), .busy(busy1), .word(word1), .word_valid(valid1), .word_ready(word_ready)
  );
  mux_scan_seq #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .sel(sel3),
    .mux_out(mo3), .busy(busy3), .word(word3), .word_valid(valid3), .word_ready(word_ready)
  );

  always_comb begin
    case (cur)
      0: begin c_sel = sel0; c_busy = busy0; c_valid = valid0; c_word = word0; end
      3: begin c_sel = sel3; c_busy = busy3; c_valid = valid3; c_word = word3; end
      default: begin c_sel = sel1; c_busy = busy1; c_valid = valid1; c_word = word1; end
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    start = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  task automatic accept(input logic [15:0] mask);
    ch_mask = mask;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Counts edges until word_valid rises (bounded) and records selects visited.
  task automatic wait_valid(output int n, output logic [15:0] vis);
    n   = 0;
    vis = '0;
    while (c_valid !== 1'b1 && n < 200) begin
      vis[c_sel] = 1'b1;
      tick();
      n++;
    end
  endtask

  int          lat;
  logic [15:0] vis;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    word_ready = 1'b1;
    ch_mask    = '0;
    in_pat     = '0;

    // Reset state of all instances.
    do_reset();
    check("rst_sel1",   32'(sel1),   32'h0);
    check("rst_busy1",  32'(busy1),  32'h0);
    check("rst_word1",  32'(word1),  32'h0);
    check("rst_valid1", 32'(valid1), 32'h0);
    check("rst_sel3",   32'(sel3),   32'h0);
    check("rst_valid0", 32'(valid0), 32'h0);

    // Full mask, SETTLE=1: each select held two cycles, valid at edge 32.
    cur    = 1;
    in_pat = 16'hA5C3;
    accept(16'hFFFF);
    for (int k = 0; k < 32; k++) begin
      check("a_sel",    32'(c_sel),   32'(k / 2));
      check("a_nvalid", 32'(c_valid), 32'h0);
      tick();
    end
    check("a_valid", 32'(c_valid), 32'h1);
    check("a_word",  32'(c_word),  32'hA5C3);
    check("a_busy",  32'(c_busy),  32'h1);
    tick();
    check("a_hs_valid", 32'(c_valid), 32'h0);
    check("a_hs_busy",  32'(c_busy),  32'h0);
    check("a_hs_word",  32'(c_word),  32'hA5C3);
    check("a_hs_sel",   32'(c_sel),   32'hF);

    // Empty mask: valid one cycle after accept, word 0, select unchanged, held until ready.
    word_ready = 1'b0;
    in_pat     = 16'hFFFF;
    accept(16'h0000);
    check("c_nvalid0", 32'(c_valid), 32'h0);
    tick();
    check("c_valid", 32'(c_valid), 32'h1);
    check("c_word",  32'(c_word),  32'h0);
    check("c_sel",   32'(c_sel),   32'hF);
    check("c_busy",  32'(c_busy),  32'h1);
    for (int k = 0; k < 5; k++) begin
      ch_mask = 16'hFFFF;
      start   = 1'b1;
      tick();
      check("c_hold_valid", 32'(c_valid), 32'h1);
      check("c_hold_word",  32'(c_word),  32'h0);
    end
    start      = 1'b0;
    word_ready = 1'b1;
    tick();
    check("c_hs_valid", 32'(c_valid), 32'h0);
    check("c_hs_busy",  32'(c_busy),  32'h0);

    // Sparse mask, SETTLE=3: only channels 0 and 15, valid at edge 8.
    cur = 3;
    do_reset();
    in_pat = 16'hFFFF;
    accept(16'h8001);
    wait_valid(lat, vis);
    check("b_lat",  32'(lat),    32'd8);
    check("b_vis",  32'(vis),    32'h8001);
    check("b_word", 32'(c_word), 32'h8001);
    check("b_sel",  32'(c_sel),  32'hF);

    // SETTLE=0: one cycle per channel, select 4..7, valid at edge 4.
    cur = 0;
    do_reset();
    in_pat = 16'h0050;
    accept(16'h00F0);
    for (int k = 0; k < 4; k++) begin
      check("d_sel",    32'(c_sel),   32'(4 + k));
      check("d_nvalid", 32'(c_valid), 32'h0);
      tick();
    end
    check("d_valid", 32'(c_valid), 32'h1);
    check("d_word",  32'(c_word),  32'h0050);

    // Start mid-scan and on the handshake cycle are ignored; next scan clears accumulator.
    cur = 1;
    do_reset();
    in_pat     = 16'hFFFF;
    word_ready = 1'b0;
    accept(16'hFFFF);
    repeat (9) tick();
    ch_mask = 16'h0001;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_valid(lat, vis);
    check("e_lat",  32'(10 + lat), 32'd32);
    check("e_word", 32'(c_word),   32'hFFFF);
    check("e_busy", 32'(c_busy),   32'h1);
    ch_mask    = 16'h0001;
    start      = 1'b1;
    word_ready = 1'b1;
    tick();
    start = 1'b0;
    check("e_hs_busy",  32'(c_busy),  32'h0);
    check("e_hs_valid", 32'(c_valid), 32'h0);
    tick();
    check("e_noacc_busy", 32'(c_busy), 32'h0);
    in_pat = 16'h0300;
    accept(16'h0F0F);
    check("e2_sel0", 32'(c_sel), 32'h0);
    wait_valid(lat, vis);
    check("e2_lat",  32'(lat),    32'd16);
    check("e2_word", 32'(c_word), 32'h0300);
    tick();

    // Reset in the middle of a full scan, then a clean scan.
    do_reset();
    in_pat = 16'hA5C3;
    accept(16'hFFFF);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("f_sel",   32'(c_sel),   32'h0);
    check("f_busy",  32'(c_busy),  32'h0);
    check("f_valid", 32'(c_valid), 32'h0);
    check("f_word",  32'(c_word),  32'h0);
    in_pat = 16'h3C5A;
    accept(16'hFFFF);
    wait_valid(lat, vis);
    check("f2_lat",  32'(lat),    32'd32);
    check("f2_word", 32'(c_word), 32'h3C5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
